lamp_fpu_div_norm_round: RTL and testbench
==========================================

Name: lamp_fpu_div_norm_round

Overview:
- Post-division normalize/round/pack stage of the LAMP FPU divide path.
- Consumes the raw fixed-point quotient produced by the fractional Newton-Raphson divider, together with sign, pre-computed biased exponent and special-case flags from the operand classifier.
- Normalizes the quotient, applies round-to-nearest-even, detects overflow/underflow and emits a packed IEEE-style float with a one-cycle valid pulse.

Parameters:
- LAMP_FLOAT_E_DW, 8, exponent field width.
- LAMP_FLOAT_F_DW, 7, stored fraction width (hidden bit excluded).
- LAMP_FLOAT_E_BIAS, 127, exponent bias (informational; the exponent input is already biased).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- doNorm_i  in  1  start pulse; sampled only in IDLE.
- quot_i  in  2*(1+F_DW)  quotient, unsigned Q2.(2*F_DW): bits [2F+1:2F] integer part, [2F-1:0] fraction.
- sign_i  in  1  result sign (XOR of operand signs).
- exp_i  in  E_DW+2  signed biased exponent, e_n - e_d + bias.
- isNaN_i  in  1  result is NaN.
- isInf_i  in  1  result is infinity.
- isZero_i  in  1  result is zero.
- res_o  out  1+E_DW+F_DW  packed result {sign, exp, frac}.
- of_o  out  1  overflow flag; valid with valid_o.
- uf_o  out  1  underflow flag; valid with valid_o.
- busy_o  out  1  high whenever the state is not IDLE.
- valid_o  out  1  one-cycle result strobe.

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE; res_o, of_o, uf_o, valid_o, busy_o and all internal registers = 0. Reset asserted mid-operation aborts the operation with no valid_o.
- FSM states: IDLE -> NORM -> ROUND -> PACK -> IDLE. Each arrow is one clock.
- IDLE: when doNorm_i = 1, latch all inputs and go to NORM. doNorm_i is ignored in every other state.
- Fixed latency: valid_o is high for exactly one cycle, 3 clocks after the start edge (the edge that samples doNorm_i). Special cases use the same latency.
- NORM:
  - if quot[2F+1] = 1: shift right by 1, exp + 1;
  - else if quot[2F] = 1: no shift;
  - else: shift left by 1, exp - 1.
  - Bits shifted out on the right OR into sticky.
  - After normalization: mantissa = hidden bit plus F fraction bits, guard = next bit, sticky = OR of all remaining lower bits.
  - A quotient of all zeros with no special flag is treated as zero.
- ROUND:
  - round-up = guard & (sticky | mantissa LSB).
  - Mantissa increment is (F+2) bits wide. If it carries out, the mantissa becomes 1.0 and exp + 1.
- PACK (result registered on the PACK -> IDLE edge, valid_o = 1):
  - isNaN: res = {0, all-ones, 1 << (F-1)}; of = uf = 0.
  - else isInf: {sign, all-ones, 0}.
  - else isZero: {sign, 0, 0}.
  - else exp >= 2^E - 1: {sign, all-ones, 0}, of_o = 1.
  - else exp <= 0: flush to {sign, 0, 0}, uf_o = 1. No subnormals are produced.
  - else: {sign, exp[E-1:0], frac}.
  - Flag priority follows this order: NaN > Inf > Zero > overflow > underflow.
- res_o, of_o and uf_o hold their values until the next PACK. valid_o is 0 in every other cycle.
- busy_o = (state != IDLE). A start issued in the cycle after valid_o is accepted (back-to-back operation).

Test Plan (F = 7, E = 8):
- quot 0x6000, exp 127, sign 0 -> res 0x3FC0, of = uf = 0; valid_o exactly 3 clocks after start; busy_o high for 3 cycles.
- quot 0x2AAA (2/3), exp 127 -> left shift, round up -> res 0x3F2B.
- Tie cases, exp 127: quot 0x4040 -> 0x3F80 (stays even); quot 0x40C0 -> 0x3F82 (rounds up).
- Mantissa carry: quot 0x7FC0, exp 127 -> 0x4000. Same quot with exp 254 -> 0x7F80, of_o = 1.
- Underflow and specials:
  - exp 0, quot 0x4000, sign 1 -> 0x8000, uf_o = 1.
  - isNaN -> 0x7FC0.
  - isInf with sign 1 -> 0xFF80.
  - Both specials at fixed latency.
- Protocol:
  - doNorm_i pulsed during NORM -> ignored, single valid_o.
  - rst asserted during ROUND -> outputs 0 immediately, no valid_o; a following op with quot 0x6000 -> 0x3FC0.

Source files
------------

// File: rtl/lamp_fpu_div_norm_round.sv
// Post-division normalize / round-to-nearest-even / pack stage of the LAMP FPU divide path.
// Fixed four-state pipeline: IDLE -> NORM -> ROUND -> PACK, result strobed on leaving PACK.
module lamp_fpu_div_norm_round #(
  parameter int unsigned LAMP_FLOAT_E_DW   = 8,
  parameter int unsigned LAMP_FLOAT_F_DW   = 7,
  parameter int unsigned LAMP_FLOAT_E_BIAS = 127
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         doNorm_i,
  input  logic [2*(1+LAMP_FLOAT_F_DW)-1:0]             quot_i,
  input  logic                                         sign_i,
  input  logic signed [LAMP_FLOAT_E_DW+1:0]            exp_i,
  input  logic                                         isNaN_i,
  input  logic                                         isInf_i,
  input  logic                                         isZero_i,
  output logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0]     res_o,
  output logic                                         of_o,
  output logic                                         uf_o,
  output logic                                         busy_o,
  output logic                                         valid_o
);

  localparam int unsigned E  = LAMP_FLOAT_E_DW;
  localparam int unsigned F  = LAMP_FLOAT_F_DW;
  localparam int unsigned QW = 2 * (1 + F);
  localparam int unsigned MW = F + 1;
  // One extra bit over the input so the two possible increments cannot wrap.
  localparam int unsigned XW = E + 3;
  localparam int unsigned RW = 1 + E + F;

  // Saturating exponent: all ones for the standard bias 2^(E-1)-1.
  localparam logic signed [XW-1:0] ExpMax  = XW'(2 * LAMP_FLOAT_E_BIAS + 1);
  localparam logic signed [XW-1:0] ExpZero = '0;

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StPack} state_e;

  state_e state_q, state_d;

  logic [QW-1:0]        quot_q, quot_d;
  logic                 sign_q, sign_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic                 nan_q, nan_d;
  logic                 inf_q, inf_d;
  logic                 zero_q, zero_d;
  logic [MW-1:0]        mant_q, mant_d;
  logic                 guard_q, guard_d;
  logic                 sticky_q, sticky_d;
  logic [RW-1:0]        res_q, res_d;
  logic                 of_q, of_d;
  logic                 uf_q, uf_d;
  logic                 valid_q, valid_d;
  logic [MW:0]          mant_inc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (doNorm_i) state_d = StNorm;
      StNorm:  state_d = StRound;
      StRound: state_d = StPack;
      StPack:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o  = (state_q != StIdle);
    res_o   = res_q;
    of_o    = of_q;
    uf_o    = uf_q;
    valid_o = valid_q;
  end

  // Datapath next-state
  always_comb begin
    quot_d   = quot_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    of_d     = of_q;
    uf_d     = uf_q;
    valid_d  = 1'b0;
    mant_inc = {1'b0, mant_q} + {{MW{1'b0}}, guard_q & (sticky_q | mant_q[0])};

    unique case (state_q)
      StIdle: begin
        if (doNorm_i) begin
          quot_d = quot_i;
          sign_d = sign_i;
          exp_d  = {exp_i[E+1], exp_i};
          nan_d  = isNaN_i;
          inf_d  = isInf_i;
          zero_d = isZero_i | ~|quot_i;
        end
      end
      StNorm: begin
        if (quot_q[QW-1]) begin
          mant_d   = quot_q[QW-1 -: MW];
          guard_d  = quot_q[QW-1-MW];
          sticky_d = |quot_q[QW-2-MW:0];
          exp_d    = exp_q + XW'(1);
        end else if (quot_q[QW-2]) begin
          mant_d   = quot_q[QW-2 -: MW];
          guard_d  = quot_q[QW-2-MW];
          sticky_d = |quot_q[QW-3-MW:0];
        end else begin
          mant_d   = quot_q[QW-3 -: MW];
          guard_d  = quot_q[QW-3-MW];
          sticky_d = |quot_q[QW-4-MW:0];
          exp_d    = exp_q - XW'(1);
        end
      end
      StRound: begin
        if (mant_inc[MW]) begin
          mant_d = {1'b1, {F{1'b0}}};
          exp_d  = exp_q + XW'(1);
        end else begin
          mant_d = mant_inc[MW-1:0];
        end
      end
      StPack: begin
        valid_d = 1'b1;
        of_d    = 1'b0;
        uf_d    = 1'b0;
        if (nan_q) begin
          res_d = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
        end else if (inf_q) begin
          res_d = {sign_q, {E{1'b1}}, {F{1'b0}}};
        end else if (zero_q) begin
          res_d = {sign_q, {(E+F){1'b0}}};
        end else if (exp_q >= ExpMax) begin
          res_d = {sign_q, {E{1'b1}}, {F{1'b0}}};
          of_d  = 1'b1;
        end else if (exp_q <= ExpZero) begin
          res_d = {sign_q, {(E+F){1'b0}}};
          uf_d  = 1'b1;
        end else begin
          res_d = {sign_q, exp_q[E-1:0], mant_q[F-1:0]};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      quot_q   <= quot_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_lamp_fpu_div_norm_round.sv
// Bench for lamp_fpu_div_norm_round: directed plan cases plus random operations,
// all checked every negedge against an arithmetic reference model.
module tb_lamp_fpu_div_norm_round;

  localparam int F = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              doNorm_i = 1'b0;
  logic [15:0]       quot_i = '0;
  logic              sign_i = 1'b0;
  logic signed [9:0] exp_i = '0;
  logic              isNaN_i = 1'b0;
  logic              isInf_i = 1'b0;
  logic              isZero_i = 1'b0;
  logic [15:0]       res_o;
  logic              of_o, uf_o, busy_o, valid_o;

  lamp_fpu_div_norm_round dut (
    .clk      (clk),
    .rst      (rst),
    .doNorm_i (doNorm_i),
    .quot_i   (quot_i),
    .sign_i   (sign_i),
    .exp_i    (exp_i),
    .isNaN_i  (isNaN_i),
    .isInf_i  (isInf_i),
    .isZero_i (isZero_i),
    .res_o    (res_o),
    .of_o     (of_o),
    .uf_o     (uf_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [15:0] res;
    logic        of_;
    logic        uf;
  } exp_t;

  exp_t        q[$];
  exp_t        held;
  logic        ev, eb;
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  // Reference: scale the quotient so the mantissa has F+1 integer bits, round the
  // discarded remainder to nearest-even, then classify the final exponent.
  function automatic logic [17:0] model(input logic [15:0] quot, input int e, input logic s,
                                        input logic nan, input logic inf, input logic zero);
    int          msb;
    int          k;
    int          ex;
    int unsigned m;
    int unsigned rem;
    int unsigned half;
    if (nan) return {2'b00, 16'h7FC0};
    if (inf) return {2'b00, s, 8'hFF, 7'h00};
    if (zero || quot == 16'h0) return {2'b00, s, 15'h0};
    msb = 0;
    for (int i = 0; i < 16; i++) if (quot[i]) msb = i;
    k    = msb - F;
    m    = 32'(quot) >> k;
    rem  = 32'(quot) & ((32'd1 << k) - 1);
    half = 32'd1 << (k - 1);
    if (rem > half || (rem == half && m % 2 == 1)) m++;
    ex = e + msb - 14;
    if (m == 256) begin
      m = 128;
      ex++;
    end
    if (ex >= 255) return {2'b10, s, 8'hFF, 7'h00};
    if (ex <= 0) return {2'b01, s, 15'h0};
    return {2'b00, s, ex[7:0], m[6:0]};
  endfunction

  // All comparisons live in this one process.
  initial begin
    logic [17:0] pin_got [6];
    logic [17:0] pin_want[6];
    pin_got[0] = model(16'h6000, 127, 1'b0, 1'b0, 1'b0, 1'b0); pin_want[0] = {2'b00, 16'h3FC0};
    pin_got[1] = model(16'h2AAA, 127, 1'b0, 1'b0, 1'b0, 1'b0); pin_want[1] = {2'b00, 16'h3F2B};
    pin_got[2] = model(16'h40C0, 127, 1'b0, 1'b0, 1'b0, 1'b0); pin_want[2] = {2'b00, 16'h3F82};
    pin_got[3] = model(16'h7FC0, 254, 1'b0, 1'b0, 1'b0, 1'b0); pin_want[3] = {2'b10, 16'h7F80};
    pin_got[4] = model(16'h4000, 0, 1'b1, 1'b0, 1'b0, 1'b0);   pin_want[4] = {2'b01, 16'h8000};
    pin_got[5] = model(16'h4040, 127, 1'b0, 1'b0, 1'b0, 1'b0); pin_want[5] = {2'b00, 16'h3F80};
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (pin_got[i] !== pin_want[i]) begin
        n_fail++;
        $display("FAIL model_pin %0d: got %h want %h", i, pin_got[i], pin_want[i]);
      end
    end
    held = '{0, 16'h0, 1'b0, 1'b0};
    #2;
    forever begin
      @(negedge clk or posedge rst);
      if (rst && clk) begin
        q.delete();
        held = '{0, 16'h0, 1'b0, 1'b0};
        #1;
        n_vec++;
        if ({valid_o, busy_o, res_o, of_o, uf_o} !== 20'h0) begin
          n_fail++;
          $display("FAIL reset_immediate: got valid=%b busy=%b res=%h of=%b uf=%b want all zero",
                   valid_o, busy_o, res_o, of_o, uf_o);
        end
      end else if (!clk) begin
        ev = 1'b0;
        eb = 1'b0;
        if (rst) begin
          q.delete();
          held = '{0, 16'h0, 1'b0, 1'b0};
        end else if (q.size() > 0) begin
          ev = (q[0].due == cyc);
          eb = (cyc + 3 >= q[0].due) && (cyc < q[0].due);
          if (ev) begin
            held = q[0];
            void'(q.pop_front());
          end
        end
        n_vec++;
        if ({valid_o, busy_o, res_o, of_o, uf_o} !== {ev, eb, held.res, held.of_, held.uf}) begin
          n_fail++;
          $display("FAIL cycle %0d outputs: got valid=%b busy=%b res=%h of=%b uf=%b, want valid=%b busy=%b res=%h of=%b uf=%b",
                   cyc, valid_o, busy_o, res_o, of_o, uf_o, ev, eb, held.res, held.of_, held.uf);
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the valid cycle.
  task automatic start_op(input logic [15:0] quot, input int e, input logic s, input logic nan,
                          input logic inf, input logic zero, input logic [17:0] want,
                          input bit mid_pulse);
    quot_i   = quot;
    exp_i    = 10'(e);
    sign_i   = s;
    isNaN_i  = nan;
    isInf_i  = inf;
    isZero_i = zero;
    doNorm_i = 1'b1;
    q.push_back('{cyc + 4, want[15:0], want[17], want[16]});
    @(posedge clk);
    #1;
    doNorm_i = 1'b0;
    if (mid_pulse) begin
      doNorm_i = 1'b1;
      quot_i   = 16'hFFFF;
      exp_i    = 10'd5;
    end
    @(posedge clk);
    #1;
    doNorm_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] quot;
    int          e;
    logic        s, nan, inf, zero;
    int unsigned r;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    start_op(16'h6000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 16'h3FC0}, 1'b0);
    start_op(16'h2AAA, 127, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 16'h3F2B}, 1'b0);
    start_op(16'h4040, 127, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 16'h3F80}, 1'b0);
    start_op(16'h40C0, 127, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 16'h3F82}, 1'b0);
    start_op(16'h7FC0, 127, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 16'h4000}, 1'b0);
    start_op(16'h7FC0, 254, 1'b0, 1'b0, 1'b0, 1'b0, {2'b10, 16'h7F80}, 1'b0);
    start_op(16'h4000, 0,   1'b1, 1'b0, 1'b0, 1'b0, {2'b01, 16'h8000}, 1'b0);
    start_op(16'h5555, 127, 1'b1, 1'b1, 1'b0, 1'b0, {2'b00, 16'h7FC0}, 1'b0);
    start_op(16'h5555, 127, 1'b1, 1'b0, 1'b1, 1'b0, {2'b00, 16'hFF80}, 1'b0);
    start_op(16'h6000, 127, 1'b1, 1'b0, 1'b0, 1'b1, {2'b00, 16'h8000}, 1'b0);
    start_op(16'h6000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 16'h3FC0}, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset during ROUND aborts the op; the checker drops the pending expectation.
    quot_i   = 16'h7FC0;
    exp_i    = 10'd100;
    doNorm_i = 1'b1;
    q.push_back('{cyc + 4, 16'h0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    doNorm_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_op(16'h6000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 16'h3FC0}, 1'b0);

    for (int n = 0; n < 300; n++) begin
      quot = 16'($urandom_range(32'h2000, 32'hFFFF));
      e    = int'($urandom_range(0, 300)) - 20;
      s    = 1'($urandom);
      r    = $urandom_range(0, 15);
      nan  = (r == 0);
      inf  = (r == 1) || (r == 0 && $urandom_range(0, 1) == 1);
      zero = (r == 2) || (r < 2 && $urandom_range(0, 1) == 1);
      if (r == 3) quot = 16'h0;
      if (r == 4) e = int'($urandom_range(0, 4)) + 251;
      if (r == 5) e = int'($urandom_range(0, 3)) - 1;
      start_op(quot, e, s, nan, inf, zero, model(quot, e, s, nan, inf, zero),
               ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
